// File: rtl/reg_dump.sv
// reg_dump: streams the 32 CPU integer registers (x0..x31) out over a
// valid/ready word interface. A dump starts on a start pulse or, when
// AUTO_HALT is set, on the rising edge of pc_in matching HALT_PC.
//
// Optional feature macro: DUMP_PC_HEADER_EN. When defined, the PC latched at
// the trigger is sent as an extra header word before x0 (33 words total).
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   start      single-cycle dump request (ignored while busy)
//   pc_in      current CPU PC, compared against HALT_PC
//   reg_sel    registered register-file debug read index
//   reg_data   combinational register-file read data for reg_sel
//   out_valid  output word valid
//   out_ready  sink accepts the word
//   out_data   dump word
//   out_last   marks the x31 word
//   busy       dump in progress (any state but IDLE)
//   done       one-cycle pulse after the x31 word is accepted
//   dbg_state  current FSM state encoding, for debug and checkers
//
// Handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both 1. Once out_valid rises it stays high, with out_data
// and out_last unchanged, until that transfer. out_valid is a function of
// FSM state only and never of out_ready; out_ready may be high at any time.

module reg_dump #(
    parameter logic [31:0] HALT_PC   = 32'h00000310,
    parameter int          AUTO_HALT = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] pc_in,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
`ifdef DUMP_PC_HEADER_EN
        S_HDR  = 3'd1,
`endif
        S_SEL  = 3'd2,
        S_CAP  = 3'd3,
        S_SEND = 3'd4,
        S_DONE = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  reg_sel_q, reg_sel_d;
    logic [31:0] out_data_q, out_data_d;
    logic        pc_match_prev_q, pc_match_prev_d;
`ifdef DUMP_PC_HEADER_EN
    logic [31:0] pc_hdr_q, pc_hdr_d;
`endif

    logic pc_match;
    logic trigger;
    logic handshake;

    assign pc_match  = (pc_in == HALT_PC);
    // Only a rising match triggers, so a PC parked on HALT_PC dumps once.
    assign trigger   = start || ((AUTO_HALT != 0) && pc_match && !pc_match_prev_q);
    assign handshake = out_valid && out_ready;

    // State register. The previous-match flag resets to 1 so that a PC
    // already sitting at HALT_PC when reset releases does not trigger.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= S_IDLE;
            idx_q           <= 5'd0;
            reg_sel_q       <= 5'd0;
            out_data_q      <= 32'd0;
            pc_match_prev_q <= 1'b1;
`ifdef DUMP_PC_HEADER_EN
            pc_hdr_q        <= 32'd0;
`endif
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            reg_sel_q       <= reg_sel_d;
            out_data_q      <= out_data_d;
            pc_match_prev_q <= pc_match_prev_d;
`ifdef DUMP_PC_HEADER_EN
            pc_hdr_q        <= pc_hdr_d;
`endif
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        reg_sel_d       = reg_sel_q;
        out_data_d      = out_data_q;
        pc_match_prev_d = pc_match;
`ifdef DUMP_PC_HEADER_EN
        pc_hdr_d        = pc_hdr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    idx_d = 5'd0;
`ifdef DUMP_PC_HEADER_EN
                    pc_hdr_d = pc_in;
                    state_d  = S_HDR;
`else
                    state_d  = S_SEL;
`endif
                end
            end
`ifdef DUMP_PC_HEADER_EN
            S_HDR: begin
                if (handshake) begin
                    state_d = S_SEL;
                end
            end
`endif
            S_SEL: begin
                reg_sel_d = idx_q;
                state_d   = S_CAP;
            end
            S_CAP: begin
                // x0 is architecturally zero regardless of what the file reads.
                out_data_d = (idx_q == 5'd0) ? 32'd0 : reg_data;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (handshake) begin
                    if (idx_q == 5'd31) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_SEL;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state only.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);
        out_data  = out_data_q;
        case (state_q)
`ifdef DUMP_PC_HEADER_EN
            S_HDR: begin
                out_valid = 1'b1;
                out_data  = pc_hdr_q;
            end
`endif
            S_SEND: begin
                out_valid = 1'b1;
                out_last  = (idx_q == 5'd31);
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign reg_sel   = reg_sel_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: directed bench for reg_dump. Register file model returns
// 32'hA000_0000 + index; the DUT must replace x0 with zero.

module tb_reg_dump;

`ifdef DUMP_PC_HEADER_EN
    localparam int NWORDS      = 33;
    localparam int FIRST_VALID = 1;
    localparam int DONE_CYC    = 98;
`else
    localparam int NWORDS      = 32;
    localparam int FIRST_VALID = 3;
    localparam int DONE_CYC    = 97;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [31:0] pc_in;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    // Clock and register file model
    always #5 clk = ~clk;
    assign reg_data = 32'hA000_0000 + {27'd0, reg_sel};

    reg_dump #(
        .HALT_PC  (32'h00000310),
        .AUTO_HALT(1)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .pc_in    (pc_in),
        .reg_sel  (reg_sel),
        .reg_data (reg_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .done     (done),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard fill: optional header, x0 as zero, then x1..x31.
    task automatic fill_exp(input logic [31:0] hdr);
        exp_q.delete();
`ifdef DUMP_PC_HEADER_EN
        exp_q.push_back(hdr);
`else
        if (hdr != hdr) exp_q.push_back(hdr);
`endif
        exp_q.push_back(32'd0);
        for (int k = 1; k < 32; k++) exp_q.push_back(32'hA000_0000 + k);
    endtask

    // Drives out_ready (mode 0: always 1, mode 1: 1-0-0-1 pattern), checks
    // every accepted word and stall stability, optionally pulses start after
    // start_at words or pulls reset after abort_at words.
    task automatic collect(input int mode, input int start_at, input int abort_at,
                           output int n, output int done_cnt,
                           output int first_cyc, output int done_cyc);
        logic        stall;
        logic [31:0] hold_d;
        logic        hold_l;
        logic [31:0] e;
        logic        el;
        int          cyc;
        int          ph;
        bit          start_done;
        n = 0; done_cnt = 0; first_cyc = -1; done_cyc = -1;
        stall = 1'b0; hold_d = '0; hold_l = 1'b0;
        cyc = 0; ph = 0; start_done = 0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            out_ready = (mode == 0) ? 1'b1 : ((ph % 4 == 0) || (ph % 4 == 3));
            ph++;
            if (stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, hold_d);
                check("hold_last", 32'(out_last), 32'(hold_l));
            end
            if (abort_at >= 0 && n == abort_at) begin
                rstn = 1'b0;
                #1;
                check("abort_valid", 32'(out_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                break;
            end
            if (start_at >= 0 && n == start_at && !start_done) begin
                start = 1'b1;
                start_done = 1;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", out_data, 32'hXXXX_XXXX);
                end else begin
                    e  = exp_q.pop_front();
                    el = (exp_q.size() == 0);
                    check($sformatf("word%0d_data", n), out_data, e);
                    check($sformatf("word%0d_last", n), 32'(out_last), 32'(el));
                end
                n++;
            end
            stall  = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
            if (done_cyc >= 0 && cyc >= done_cyc + 5) break;
        end
    endtask

    initial begin
        int n, dc, fc, dcy;
        rstn = 1'b0; start = 1'b0; out_ready = 1'b0; pc_in = 32'h100;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_sel", 32'(reg_sel), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Plain dump via start, ready held high (set before valid)
        out_ready = 1'b1;
        fill_exp(32'h100);
        start = 1'b1;
        collect(0, -1, -1, n, dc, fc, dcy);
        check("t1_count", n, NWORDS);
        check("t1_done", dc, 1);
        check("t1_first", fc, FIRST_VALID);
        check("t1_done_cyc", dcy, DONE_CYC);
        check("t1_left", exp_q.size(), 0);
        check("t1_busy", 32'(busy), 32'd0);

        // Back-pressure 1-0-0-1
        fill_exp(32'h100);
        @(negedge clk);
        start = 1'b1;
        collect(1, -1, -1, n, dc, fc, dcy);
        check("t2_count", n, NWORDS);
        check("t2_done", dc, 1);
        check("t2_left", exp_q.size(), 0);

        // start while busy is ignored
        fill_exp(32'h100);
        @(negedge clk);
        start = 1'b1;
        collect(0, 10, -1, n, dc, fc, dcy);
        check("t3_count", n, NWORDS);
        check("t3_done", dc, 1);
        repeat (10) @(negedge clk);
        check("t3_no_requeue", 32'(busy), 32'd0);

        // Reset mid-dump aborts without done
        fill_exp(32'h100);
        @(negedge clk);
        start = 1'b1;
        collect(0, -1, 17, n, dc, fc, dcy);
        check("t4_done", dc, 0);
        repeat (2) @(negedge clk);
        check("t4_rst_done", 32'(done), 32'd0);
        check("t4_rst_valid", 32'(out_valid), 32'd0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("t4_no_restart", 32'(busy), 32'd0);
        fill_exp(32'h100);
        start = 1'b1;
        collect(0, -1, -1, n, dc, fc, dcy);
        check("t4_count", n, NWORDS);
        check("t4_redone", dc, 1);
        check("t4_left", exp_q.size(), 0);

        // Reset release with pc already at HALT_PC: no trigger
        rstn = 1'b0;
        pc_in = 32'h310;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_no_trig", 32'(busy), 32'd0);
        check("t5_no_valid", 32'(out_valid), 32'd0);
        pc_in = 32'h0;
        repeat (2) @(negedge clk);

        // PC match trigger, held: exactly one dump
        pc_in = 32'h310;
        fill_exp(32'h310);
        collect(0, -1, -1, n, dc, fc, dcy);
        check("t6_count", n, NWORDS);
        check("t6_done", dc, 1);
        check("t6_first", fc, FIRST_VALID);
        repeat (30) @(negedge clk);
        check("t6_once", 32'(busy), 32'd0);

        // PC leaves and returns: second dump
        pc_in = 32'h314;
        repeat (3) @(negedge clk);
        pc_in = 32'h310;
        fill_exp(32'h310);
        collect(0, -1, -1, n, dc, fc, dcy);
        check("t7_count", n, NWORDS);
        check("t7_done", dc, 1);
        check("t7_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 The block SHALL have parameter HALT_PC, default 32'h00000310, the PC value that triggers an automatic dump.
REQ-002 The block SHALL have parameter AUTO_HALT, default 1, where 1 enables the PC-match trigger and 0 allows start-only triggering.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle dump request.
REQ-006 The block SHALL have port pc_in, input, 32 bits: current CPU PC.
REQ-007 The block SHALL have port reg_sel, output, 5 bits, registered: register-file debug read index.
REQ-008 The block SHALL have port reg_data, input, 32 bits: combinational register-file read data for reg_sel.
REQ-009 The block SHALL have port out_valid, output, 1 bit: output word valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: sink accepts the word.
REQ-011 The block SHALL have port out_data, output, 32 bits: dump word.
REQ-012 The block SHALL have port out_last, output, 1 bit: marks the x31 word.
REQ-013 The block SHALL have ports busy and done, outputs, 1 bit each: busy means dump in progress; done is a one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, HDR, SEL, CAP, SEND and DONE; HDR is reachable only when DUMP_PC_HEADER_EN is defined.
REQ-015 In IDLE, the FSM SHALL trigger on start, or on AUTO_HALT=1 with pc_in==HALT_PC while the previous cycle's pc_in!=HALT_PC (rising match), and only on such a rising match.
REQ-016 On trigger, the FSM SHALL load idx=0, latch pc_in into pc_hdr, and go to HDR if the macro is defined, otherwise to SEL.
REQ-017 SEL SHALL drive reg_sel<=idx and go to CAP the next cycle.
REQ-018 CAP SHALL capture out_data<=(idx==0 ? 32'h0 : reg_data) and go to SEND.
REQ-019 SEND SHALL hold out_valid=1 with out_data and out_last stable until out_valid&&out_ready.
REQ-020 On a SEND handshake, the FSM SHALL go to DONE if idx==31, otherwise set idx<=idx+1 and go to SEL.
REQ-021 out_last SHALL be 1 only in SEND with idx==31.
REQ-022 DONE SHALL assert done=1 for exactly one cycle and then go to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 start or a PC match occurring while busy SHALL be ignored and never queued.
REQ-025 Latency: the first register word SHALL be valid 3 cycles after the trigger edge (trigger, SEL, CAP, then SEND); with out_ready held at 1, each word SHALL take 3 cycles.
REQ-026 out_ready SHALL be allowed high before out_valid; out_valid SHALL never depend combinationally on out_ready.
REQ-027 idx SHALL be 5 bits, and the block SHALL never wrap idx past 31 within a dump.

Reset
REQ-028 When rstn=0, the block SHALL asynchronously force: state=IDLE, idx=0, reg_sel=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, pc_hdr=0, and the previous-PC-match flag=1, which suppresses a spurious trigger when pc_in==HALT_PC at release.
REQ-029 Reset asserted mid-dump SHALL abort the dump immediately without a done pulse.
REQ-030 After reset release, the block SHALL require a new trigger.

Configuration
REQ-031 When DUMP_PC_HEADER_EN is defined, the block SHALL emit one header word before x0: HDR drives out_valid=1 with out_data=pc_hdr and out_last=0, and goes to SEL after the handshake; a full dump is then 33 words.
REQ-032 When DUMP_PC_HEADER_EN is undefined, the HDR state and pc_hdr logic SHALL be absent; a dump is 32 words, and the first word is valid 3 cycles after the trigger.

Verification
REQ-033 Reset then a start pulse, out_ready=1, rf[k]=32'hA000_0000+k, macro off -> 32 words: 0, A0000001 ... A000001F; out_last on the 32nd word only; done pulses once about 96 cycles after start.
REQ-034 pc_in steps to 32'h00000310 and is held for 50 cycles, AUTO_HALT=1 -> exactly one dump; pc_in leaves and returns to 310 -> a second dump.
REQ-035 out_ready toggles 1-0-0-1 repeatedly -> out_data and out_last stay stable while out_valid=1 and out_ready=0; the word sequence is unchanged and there are no duplicates.
REQ-036 start is pulsed again at word 10 -> ignored; the count stays at 32 with a single done.
REQ-037 rstn is pulled low during word 17 -> out_valid=0 and busy=0 asynchronously with no done; a start after release restarts at x0.
REQ-038 Macro on, trigger at pc_in=32'h00000310 -> first word 00000310, then 32 register words; out_last on word 33.
